// File: rtl/icache_refill_ctrl_if.sv
// Bundles the CPU fetch, tag-FIFO, memory and data-array refill signals of the refill controller.
// master = controller side, slave = surrounding cache/memory side.
`ifndef TAG_XLEN
`define TAG_XLEN 8
`endif

interface icache_refill_ctrl_if #(
    parameter int TW    = `TAG_XLEN,
    parameter int DP    = 4,
    parameter int BEATS = 4
);
    localparam int AW = $clog2(DP);
    localparam int BW = $clog2(BEATS);

    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic [TW-1:0] cpu_req_tag;
    logic          cpu_hit;
    logic [AW-1:0] cpu_hit_index;
    logic          cpu_err;
    logic [TW-1:0] tag_cmp_data;
    logic [DP-1:0] tag_hit;
    logic [AW-1:0] tag_hindex;
    logic [AW-1:0] tag_wptr;
    logic          tag_wr;
    logic          tag_uwr;
    logic [AW-1:0] tag_uptr;
    logic [TW:0]   tag_wdata;
    logic          mem_req;
    logic [TW-1:0] mem_tag;
    logic          mem_ack;
    logic          mem_rvalid;
    logic          mem_rerr;
    logic          refill_wr;
    logic [AW-1:0] refill_index;
    logic [BW-1:0] refill_beat;

    modport master (
        input  cpu_req_valid, cpu_req_tag, tag_hit, tag_hindex, tag_wptr,
               mem_ack, mem_rvalid, mem_rerr,
        output cpu_req_ready, cpu_hit, cpu_hit_index, cpu_err, tag_cmp_data,
               tag_wr, tag_uwr, tag_uptr, tag_wdata, mem_req, mem_tag,
               refill_wr, refill_index, refill_beat
    );

    modport slave (
        output cpu_req_valid, cpu_req_tag, tag_hit, tag_hindex, tag_wptr,
               mem_ack, mem_rvalid, mem_rerr,
        input  cpu_req_ready, cpu_hit, cpu_hit_index, cpu_err, tag_cmp_data,
               tag_wr, tag_uwr, tag_uptr, tag_wdata, mem_req, mem_tag,
               refill_wr, refill_index, refill_beat
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache lookup/miss controller: tag compare, victim invalidate, line refill from
// memory into the FIFO-replacement slot, then tag install and re-lookup.
`ifndef TAG_XLEN
`define TAG_XLEN 8
`endif

module icache_refill_ctrl #(
    parameter int TW    = `TAG_XLEN,
    parameter int DP    = 4,
    parameter int BEATS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    icache_refill_ctrl_if.master bus
);
    localparam int AW = $clog2(DP);
    localparam int BW = $clog2(BEATS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_INVAL, S_MISS_REQ, S_REFILL, S_TAG_WR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tag;
    logic [AW-1:0] r_victim;
    logic [AW-1:0] r_hit_index;
    logic [BW-1:0] r_beat;
    logic          r_hit;
    logic          r_err;

    logic w_any_hit;
    logic w_beat_ok;
    logic w_beat_err;
    logic w_last_beat;

    assign w_any_hit   = |bus.tag_hit;
    assign w_beat_ok   = (r_state == S_REFILL) && bus.mem_rvalid && !bus.mem_rerr && !flush;
    assign w_beat_err  = (r_state == S_REFILL) && bus.mem_rvalid && bus.mem_rerr && !flush;
    assign w_last_beat = (r_beat == BW'(BEATS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.cpu_req_valid) w_next = S_LOOKUP;
            S_LOOKUP:   w_next = w_any_hit ? S_IDLE : S_INVAL;
            S_INVAL:    w_next = S_MISS_REQ;
            S_MISS_REQ: if (bus.mem_ack) w_next = S_REFILL;
            S_REFILL: begin
                if (w_beat_err)                    w_next = S_IDLE;
                else if (w_beat_ok && w_last_beat) w_next = S_TAG_WR;
            end
            S_TAG_WR:   w_next = S_LOOKUP;
            default:    w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tag       <= '0;
            r_victim    <= '0;
            r_hit_index <= '0;
            r_beat      <= '0;
            r_hit       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
            if (flush) begin
                r_beat   <= '0;
                r_victim <= '0;
            end else begin
                case (r_state)
                    S_IDLE:     if (bus.cpu_req_valid) r_tag <= bus.cpu_req_tag;
                    S_LOOKUP: begin
                        if (w_any_hit) begin
                            r_hit       <= 1'b1;
                            r_hit_index <= bus.tag_hindex;
                        end else begin
                            r_victim <= bus.tag_wptr;
                        end
                    end
                    S_MISS_REQ: if (bus.mem_ack) r_beat <= '0;
                    S_REFILL: begin
                        // Counter wraps BEATS-1 -> 0 naturally on the final beat.
                        if (w_beat_ok) r_beat <= r_beat + 1'b1;
                        else if (w_beat_err) begin
                            r_beat <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A flush cycle suppresses both tag writes and the request handshake.
    assign bus.cpu_req_ready = (r_state == S_IDLE) && !flush;
    assign bus.cpu_hit       = r_hit;
    assign bus.cpu_hit_index = r_hit_index;
    assign bus.cpu_err       = r_err;
    assign bus.tag_cmp_data  = r_tag;
    assign bus.tag_uwr       = (r_state == S_INVAL) && !flush;
    assign bus.tag_uptr      = r_victim;
    assign bus.tag_wr        = (r_state == S_TAG_WR) && !flush;
    assign bus.tag_wdata     = bus.tag_wr ? {1'b1, r_tag} : '0;
    assign bus.mem_req       = (r_state == S_MISS_REQ);
    assign bus.mem_tag       = r_tag;
    assign bus.refill_wr     = w_beat_ok;
    assign bus.refill_index  = r_victim;
    assign bus.refill_beat   = r_beat;
endmodule
